// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the pipelined immediate generator.
// extend_imm turns a decoded payload into the final immediate and Illegal flag.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_B    = 3'd1,
    FMT_CB   = 3'd2,
    FMT_D    = 3'd3,
    FMT_I    = 3'd4,
    FMT_IW   = 3'd5
  } fmt_e;

  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;

  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;

  localparam logic [10:0] OP_STURB = 11'b00111000000;
  localparam logic [10:0] OP_LDURB = 11'b00111000010;
  localparam logic [10:0] OP_STURH = 11'b01111000000;
  localparam logic [10:0] OP_LDURH = 11'b01111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;

  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OP_SUBIS = 10'b1111000100;
  localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
  localparam logic [9:0]  OP_EORI  = 10'b1101001000;
  localparam logic [9:0]  OP_ANDIS = 10'b1111001000;

  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
  localparam logic [8:0]  OP_MOVK  = 9'b111100101;

  // raw holds the format's immediate field right-aligned; hw is the IW shift selector
  typedef struct packed {
    fmt_e        fmt;
    logic [25:0] raw;
    logic [1:0]  hw;
  } s1_payload_t;

  // Result is {illegal, 64-bit immediate}; callers truncate to their width.
  function automatic logic [64:0] extend_imm(input s1_payload_t p,
                                             input int unsigned data_w,
                                             input logic br_shift);
    logic [63:0] v;
    logic        ill;
    v   = '0;
    ill = 1'b0;
    case (p.fmt)
      FMT_B:  v = {{38{p.raw[25]}}, p.raw};
      FMT_CB: v = {{45{p.raw[18]}}, p.raw[18:0]};
      FMT_D:  v = {{55{p.raw[8]}}, p.raw[8:0]};
      FMT_I:  v = {52'b0, p.raw[11:0]};
      FMT_IW: begin
        if (data_w == 32 && p.hw[1]) ill = 1'b1;
        else v = {48'b0, p.raw[15:0]} << {p.hw, 4'b0000};
      end
      default: v = '0;
    endcase
    if (br_shift && (p.fmt == FMT_B || p.fmt == FMT_CB)) v = v << 2;
    return {ill, v};
  endfunction

endpackage

// File: rtl/imm_fmt_decode.sv
// Combinational instruction classifier: picks the immediate format and
// slices out its raw field, first match wins.
module imm_fmt_decode
  import imm_gen_pkg::*;
(
  input  logic [31:0]  inst,
  output s1_payload_t  pay
);

  always_comb begin
    pay.fmt = FMT_NONE;
    pay.raw = '0;
    pay.hw  = '0;
    if (inst[31:26] == OP_B || inst[31:26] == OP_BL) begin
      pay.fmt = FMT_B;
      pay.raw = inst[25:0];
    end else if (inst[31:24] == OP_BCOND || inst[31:24] == OP_CBZ ||
                 inst[31:24] == OP_CBNZ) begin
      pay.fmt = FMT_CB;
      pay.raw = {7'b0, inst[23:5]};
    end else if (inst[31:21] inside {OP_STURB, OP_LDURB, OP_STURH,
                                     OP_LDURH, OP_STUR, OP_LDUR}) begin
      pay.fmt = FMT_D;
      pay.raw = {17'b0, inst[20:12]};
    end else if (inst[31:22] inside {OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
                                     OP_ANDI, OP_ORRI, OP_EORI, OP_ANDIS}) begin
      pay.fmt = FMT_I;
      pay.raw = {14'b0, inst[21:10]};
    end else if (inst[31:23] == OP_MOVZ || inst[31:23] == OP_MOVK) begin
      pay.fmt = FMT_IW;
      pay.raw = {10'b0, inst[20:5]};
      pay.hw  = inst[22:21];
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with valid/ready on both sides.
// STAGES=2 registers the decoded payload before extension; STAGES=1 does both in one stage.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int BR_SHIFT = 1,
  parameter int STAGES   = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       Inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] BusImm,
  output logic [2:0]        Fmt,
  output logic              Illegal
);

  s1_payload_t dec_pay;
  s1_payload_t src_pay;
  logic        src_valid;
  logic        out_en;
  logic [64:0] ext;

  imm_fmt_decode u_dec (
    .inst (Inst),
    .pay  (dec_pay)
  );

  assign out_en = !out_valid || out_ready;

  generate
    if (STAGES == 1) begin : g_one
      assign src_valid = in_valid;
      assign src_pay   = dec_pay;
      assign in_ready  = out_en;
    end else begin : g_two
      logic        s1_valid;
      s1_payload_t s1_pay;
      logic        s1_ready;

      assign s1_ready  = !s1_valid || out_en;
      assign in_ready  = s1_ready;
      assign src_valid = s1_valid;
      assign src_pay   = s1_pay;

      always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
          s1_valid <= 1'b0;
          s1_pay   <= '0;
        end else if (s1_ready) begin
          s1_valid <= in_valid;
          if (in_valid) s1_pay <= dec_pay;
        end
      end
    end
  endgenerate

  assign ext = extend_imm(src_pay, DATA_W, BR_SHIFT != 0);

  // Output register only advances when empty or being drained, so data holds under stall.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      BusImm    <= '0;
      Fmt       <= '0;
      Illegal   <= 1'b0;
    end else if (out_en) begin
      out_valid <= src_valid;
      if (src_valid) begin
        BusImm  <= ext[DATA_W-1:0];
        Fmt     <= src_pay.fmt;
        Illegal <= ext[64];
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: three configurations share Inst/out_ready,
// each has its own in_valid, expected queue and output monitor.
module tb_imm_gen_pipe;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Inst = '0;
  logic        out_ready = 1'b1;
  logic        iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, il0, il1, il2;
  logic [63:0] bi0, bi1;
  logic [31:0] bi2;
  logic [2:0]  fm0, fm1, fm2;

  always #5 CLK = ~CLK;

  // u0: 64-bit word offsets; u1: 64-bit byte offsets; u2: 32-bit single stage
  imm_gen_pipe #(.DATA_W(64), .BR_SHIFT(0), .STAGES(2)) u0 (
    .CLK(CLK), .Reset(Reset), .in_valid(iv0), .in_ready(ir0), .Inst(Inst),
    .out_valid(ov0), .out_ready(out_ready), .BusImm(bi0), .Fmt(fm0), .Illegal(il0));
  imm_gen_pipe #(.DATA_W(64), .BR_SHIFT(1), .STAGES(2)) u1 (
    .CLK(CLK), .Reset(Reset), .in_valid(iv1), .in_ready(ir1), .Inst(Inst),
    .out_valid(ov1), .out_ready(out_ready), .BusImm(bi1), .Fmt(fm1), .Illegal(il1));
  imm_gen_pipe #(.DATA_W(32), .BR_SHIFT(1), .STAGES(1)) u2 (
    .CLK(CLK), .Reset(Reset), .in_valid(iv2), .in_ready(ir2), .Inst(Inst),
    .out_valid(ov2), .out_ready(out_ready), .BusImm(bi2), .Fmt(fm2), .Illegal(il2));

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int id);
    case (id)
      0: return ir0;
      1: return ir1;
      default: return ir2;
    endcase
  endfunction

  task automatic set_iv(input int id, input logic v);
    case (id)
      0: iv0 = v;
      1: iv1 = v;
      default: iv2 = v;
    endcase
  endtask

  // Called 1ns after a rising edge; returns 1ns after the accepting edge.
  task automatic send(input int id, input logic [31:0] ins, input logic [63:0] imm,
                      input logic [2:0] fmt, input logic ill);
    int n;
    exp_t e;
    n = 0;
    Inst = ins;
    set_iv(id, 1'b1);
    @(negedge CLK);
    while (!rdy(id) && n < 50) begin
      n++;
      @(negedge CLK);
    end
    if (!rdy(id)) begin
      checks++;
      errors++;
      $display("FAIL send_timeout id=%0d inst=%h: in_ready stayed 0, required 1", id, ins);
      set_iv(id, 1'b0);
      return;
    end
    @(posedge CLK);
    e.imm = imm; e.fmt = fmt; e.ill = ill;
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    #1 set_iv(id, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      @(posedge CLK);
      n++;
    end
    chk("drain_pending", q0.size() + q1.size() + q2.size(), 0);
    @(posedge CLK); #1;
  endtask

  logic        held_v[3];
  logic [63:0] held_imm[3];
  logic [2:0]  held_fmt[3];
  logic        held_ill[3];
  logic        m_v, m_l, m_got;
  logic [63:0] m_bi;
  logic [2:0]  m_f;
  exp_t        m_e;

  always @(negedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < 3; i++) held_v[i] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        case (i)
          0: begin m_v = ov0; m_bi = bi0; m_f = fm0; m_l = il0; end
          1: begin m_v = ov1; m_bi = bi1; m_f = fm1; m_l = il1; end
          default: begin m_v = ov2; m_bi = {32'b0, bi2}; m_f = fm2; m_l = il2; end
        endcase
        if (m_v && !out_ready) begin
          if (held_v[i]) begin
            chk($sformatf("hold_imm%0d", i), m_bi, held_imm[i]);
            chk($sformatf("hold_fmt%0d", i), m_f, held_fmt[i]);
            chk($sformatf("hold_ill%0d", i), m_l, held_ill[i]);
          end
          held_v[i] = 1'b1; held_imm[i] = m_bi; held_fmt[i] = m_f; held_ill[i] = m_l;
        end else begin
          held_v[i] = 1'b0;
        end
        if (m_v && out_ready) begin
          m_got = 1'b0;
          case (i)
            0: if (q0.size() > 0) begin m_e = q0.pop_front(); m_got = 1'b1; end
            1: if (q1.size() > 0) begin m_e = q1.pop_front(); m_got = 1'b1; end
            default: if (q2.size() > 0) begin m_e = q2.pop_front(); m_got = 1'b1; end
          endcase
          if (!m_got) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out%0d: got imm=%h fmt=%0d, expected no output", i, m_bi, m_f);
          end else begin
            chk($sformatf("imm%0d", i), m_bi, m_e.imm);
            chk($sformatf("fmt%0d", i), m_f, m_e.fmt);
            chk($sformatf("ill%0d", i), m_l, m_e.ill);
          end
        end
      end
    end
  end

  int n;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", ov0, 0);
    chk("rst_busimm", bi0, 0);
    chk("rst_fmt", fm0, 0);
    chk("rst_illegal", il0, 0);
    Reset = 1'b0;
    @(posedge CLK); #1;
    chk("rst_in_ready", ir0, 1);

    // u0: every format, back to back
    send(0, 32'h17FFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    send(0, 32'hB4000040, 64'h2,                3'd2, 1'b0);
    send(0, 32'hF85F8000, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0);
    send(0, 32'h91003C00, 64'hF,                3'd4, 1'b0);
    send(0, 32'hD2E24680, 64'h1234000000000000, 3'd5, 1'b0);
    send(0, 32'hF13FFC00, 64'hFFF,              3'd4, 1'b0);
    send(0, 32'h8B000000, 64'h0,                3'd0, 1'b0);
    drain();

    // u1: byte-offset branches
    send(1, 32'h14000004, 64'h10,               3'd1, 1'b0);
    send(1, 32'h54FFFFE0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
    drain();

    // u2: 32-bit wide, IW shift legality
    send(2, 32'hD2C24680, 64'h0,        3'd5, 1'b1);
    send(2, 32'hD2B579A0, 64'hABCD0000, 3'd5, 1'b0);
    send(2, 32'hF2E00000, 64'h0,        3'd5, 1'b1);
    send(2, 32'h14000004, 64'h10,       3'd1, 1'b0);
    drain();

    // latency, counted in cycles from the presenting cycle
    send(0, 32'h8B000000, 64'h0, 3'd0, 1'b0);
    n = 0;
    while (!ov0 && n < 10) begin @(posedge CLK); #1; n++; end
    chk("latency_stages2", n + 1, 2);
    drain();
    send(2, 32'h91003C00, 64'hF, 3'd4, 1'b0);
    n = 0;
    while (!ov2 && n < 10) begin @(posedge CLK); #1; n++; end
    chk("latency_stages1", n + 1, 1);
    drain();

    // backpressure on u0
    out_ready = 1'b0;
    send(0, 32'h14000001, 64'h1, 3'd1, 1'b0);
    send(0, 32'h14000002, 64'h2, 3'd1, 1'b0);
    chk("bp_in_ready", ir0, 0);
    chk("bp_out_valid", ov0, 1);
    fork
      begin
        send(0, 32'h14000003, 64'h3, 3'd1, 1'b0);
        send(0, 32'h14000004, 64'h4, 3'd1, 1'b0);
      end
      begin
        repeat (4) @(posedge CLK);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // reset with two instructions in flight
    out_ready = 1'b0;
    send(0, 32'hB4000040, 64'h2, 3'd2, 1'b0);
    send(0, 32'h91003C00, 64'hF, 3'd4, 1'b0);
    chk("pre_reset_valid", ov0, 1);
    Reset = 1'b1;
    #1;
    chk("reset_async_valid", ov0, 0);
    q0.delete();
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;
    @(posedge CLK); #1;
    chk("post_reset_in_ready", ir0, 1);
    chk("post_reset_valid", ov0, 0);
    out_ready = 1'b1;
    send(0, 32'hD2E24680, 64'h1234000000000000, 3'd5, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the ARMv8-subset datapath.
- Decodes a 32-bit instruction into one of five immediate formats: B, CB, D, I, IW.
- Produces a DATA_W-bit extended immediate, a format code and an illegal flag.
- Sits between instruction fetch/decode and the ALU/branch-target adder, with a valid/ready handshake on both sides so the block can stall with a pipelined core.

Parameters:
- DATA_W, 64, immediate output width; legal values are 32 and 64.
- BR_SHIFT, 1, when 1, B and CB offsets are left-shifted by 2 (byte offset); when 0, they are word offset.
- STAGES, 2, pipeline depth; legal values are 1 (decode and extend in one register stage) and 2 (decode register, then extend register).

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- in_valid  in  1  Inst is valid this cycle
- in_ready  out  1  block accepts Inst this cycle
- Inst  in  32  instruction word
- out_valid  out  1  BusImm/Fmt/Illegal are valid
- out_ready  in  1  consumer accepts output this cycle
- BusImm  out  DATA_W  extended immediate
- Fmt  out  3  0=NONE 1=B 2=CB 3=D 4=I 5=IW
- Illegal  out  1  IW shift not representable in DATA_W

Behaviour:
- Clock and reset: one clock (CLK); reset is asynchronous and active-high (Reset).
- Reset values: out_valid=0, BusImm=0, Fmt=0, Illegal=0, all stage valids=0. in_ready=1 one cycle after Reset deasserts.
- Reset mid-operation: all in-flight instructions are discarded. No output handshake completes while Reset is high.
- Handshake:
  - Transfer occurs when valid&&ready on a port.
  - Each stage: stage_ready = !stage_valid || next_ready, where the last stage's next_ready is out_ready. in_ready is stage-1 ready.
  - Combinational ready path is permitted.
  - While out_valid=1 && out_ready=0, BusImm/Fmt/Illegal are held stable.
- Latency:
  - STAGES=2: accepted at edge N gives out_valid at N+2 when unstalled.
  - STAGES=1: out_valid at N+1.
  - Throughput: 1 instruction per cycle when out_ready is held high.
- Decode priority (first match wins):
  - B: Inst[31:26] is 000101 or 100101 -> sign-extend Inst[25:0].
  - CB: Inst[31:24] is 01010100, 10110100 or 10110101 -> sign-extend Inst[23:5].
  - D: Inst[31:21] is one of 00111000000, 00111000010, 01111000000, 01111000010, 11111000000, 11111000010 -> sign-extend Inst[20:12].
  - I: Inst[31:22] is one of 1001000100, 1011000100, 1101000100, 1111000100, 1001001000, 1011001000, 1101001000, 1111001000 -> zero-extend Inst[21:10].
  - IW: Inst[31:23] is 110100101 (MOVZ) or 111100101 (MOVK) -> zero-extend Inst[20:5], then shift left by 16*Inst[22:21].
  - None of the above: Fmt=0, BusImm=0.
- BR_SHIFT=1: B/CB results are shifted left by 2 after sign extension. Bits shifted out past DATA_W are dropped.
- Illegal: DATA_W=32 && Fmt=IW && Inst[22:21]>=2 -> Illegal=1, BusImm=0. Illegal=0 in all other cases.
- Stage-1 register holds Fmt and the raw fields. Stage-2 performs extend/shift.

Decomposition:
- Package imm_gen_pkg holds:
  - fmt encodings FMT_NONE..FMT_IW.
  - opcode constants for each format.
  - a typedef for the stage-1 payload {fmt, raw fields}.
- Sub-module imm_fmt_decode: combinational Inst -> Fmt plus raw field slices, shared by both STAGES configurations.

Test Plan:
- Format coverage, DATA_W=64, BR_SHIFT=0:
  - B 0x17FFFFFF -> Fmt=1, BusImm=0xFFFFFFFFFFFFFFFF.
  - CBZ 0xB4000040 -> Fmt=2, BusImm=2.
  - LDUR 0xF85F8000 -> Fmt=3, BusImm=0xFFFFFFFFFFFFFFF8.
  - ADDI 0x91003C00 -> Fmt=4, BusImm=0xF.
  - MOVZ 0xD2E24680 (hw=3, imm=0x1234) -> Fmt=5, BusImm=0x1234000000000000.
- BR_SHIFT=1: B 0x14000004 -> BusImm=0x10. CB 0x54FFFFE0 -> BusImm=0xFFFFFFFFFFFFFFFC.
- Backpressure, STAGES=2: stream 4 instructions with out_ready held low for 5 cycles.
  - in_ready drops after 2 accepted.
  - Outputs are held stable.
  - On release, all 4 emerge in order with no loss or duplication.
- Reset mid-stream: assert Reset while 2 instructions are in flight.
  - out_valid=0 immediately (asynchronous).
  - After release, the next output is the first post-reset instruction.
- DATA_W=32: MOVZ hw=2 -> Illegal=1, BusImm=0. MOVZ hw=1 imm=0xABCD -> BusImm=0xABCD0000, Illegal=0.
- Unmatched 0x8B000000 (ADD R-type) -> Fmt=0, BusImm=0. Latency is 2 cycles with out_ready=1, checked by cycle count.
